// File: rtl/pos_mem_arbiter.sv
// rtl/pos_mem_arbiter.sv - round-robin read arbiter for the shared position memory
// Loader writes pre-empt solver reads; read returns are tracked by a {valid, id} pipeline.
module pos_mem_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ADDR_LEN = 12,
   parameter int DATA_W   = 96,
   parameter int RD_LAT   = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*ADDR_LEN-1:0] req_addr,
   output logic [NUM_REQ-1:0]          grant,
   output logic [NUM_REQ-1:0]          rvalid,
   output logic [DATA_W-1:0]           rdata,
   input  logic                        ext_we,
   input  logic [ADDR_LEN-1:0]         ext_addr,
   input  logic [DATA_W-1:0]           ext_wdata,
   output logic [ADDR_LEN-1:0]         mem_addr,
   output logic                        mem_we,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic [15:0]                 conflict_count
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0] grant_idx;
   logic             grant_found;
   logic             issue;
   logic [PTR_W:0]   cand_sum;
   logic [PTR_W-1:0] cand;

   logic             pipe_vld_q [RD_LAT];
   logic             pipe_vld_d [RD_LAT];
   logic [PTR_W-1:0] pipe_id_q  [RD_LAT];
   logic [PTR_W-1:0] pipe_id_d  [RD_LAT];

   logic [15:0]      conflict_count_q, conflict_count_d;

   // First requester at or above rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand_sum    = '0;
      cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (cand_sum >= (PTR_W+1)'(NUM_REQ)) begin
            cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
         end
         cand = cand_sum[PTR_W-1:0];
         if (!grant_found && req[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
      issue = grant_found && !reset && !ext_we;
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (reset) begin
         rr_ptr_d = '0;
      end else if (issue) begin
         rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
      end

      pipe_vld_d[0] = issue;
      pipe_id_d[0]  = grant_idx;
      for (int i = 1; i < RD_LAT; i++) begin
         pipe_vld_d[i] = pipe_vld_q[i-1];
         pipe_id_d[i]  = pipe_id_q[i-1];
      end
      // Dropping the valids discards any read still in flight.
      if (reset) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_vld_d[i] = 1'b0;
         end
      end

      conflict_count_d = conflict_count_q;
      if (reset) begin
         conflict_count_d = '0;
      end else if (((req & ~grant) != '0) && (conflict_count_q != 16'hFFFF)) begin
         conflict_count_d = conflict_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      rr_ptr_q         <= rr_ptr_d;
      pipe_vld_q       <= pipe_vld_d;
      pipe_id_q        <= pipe_id_d;
      conflict_count_q <= conflict_count_d;
   end

   always_comb begin
      grant = '0;
      if (issue) begin
         grant[grant_idx] = 1'b1;
      end
      rvalid = '0;
      if (pipe_vld_q[RD_LAT-1]) begin
         rvalid[pipe_id_q[RD_LAT-1]] = 1'b1;
      end
      rdata          = mem_rdata;
      mem_we         = ext_we && !reset;
      mem_addr       = ext_we ? ext_addr : req_addr[grant_idx*ADDR_LEN +: ADDR_LEN];
      mem_wdata      = ext_wdata;
      conflict_count = conflict_count_q;
   end

endmodule
